// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// -----------------
// Shares one single-port SRAM between two requesters of the SHA256 datapath:
// requester 0 (message/constant loader) and requester 1 (hash-result writeback).
// Round-robin arbitration with a req/gnt handshake, one accepted access per
// cycle, a registered SRAM command stage and a registered read-return stage.
//
// Optional feature: define SRAM_ARB_LOCK_EN to add r0_lock/r1_lock inputs.
// A requester granted with lock=1 keeps exclusive ownership of the port
// until its req or lock drops.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   rX_req/write/addr/wdata request side of requester X (held until gnt)
//   rX_lock                 ownership request (SRAM_ARB_LOCK_EN only)
//   rX_gnt                  combinational accept of requester X this cycle
//   rX_rvalid/rX_rdata      one-cycle read return pulse and held read data
//   sram_*                  registered command to the SRAM, sram_read_data back
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_write,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_write,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
`ifdef SRAM_ARB_LOCK_EN
    input  logic                  r0_lock,
    input  logic                  r1_lock,
`endif
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  sram_enable,
    output logic                  sram_write
);

    logic last_grant;   // index of the most recently granted requester
    logic gnt0, gnt1;
    logic xfer;         // an access is accepted on the coming edge
    logic sel;          // index of the accepted requester
    logic tag_p1;       // originating requester of the command in stage 1

`ifdef SRAM_ARB_LOCK_EN
    logic own_vld;      // a requester currently owns the port
    logic own_idx;
    logic own_active;   // owner still asks with req and lock this cycle
    logic sel_lock;

    always_comb begin
        own_active = 1'b0;
        if (own_vld) begin
            own_active = own_idx ? (r1_req && r1_lock) : (r0_req && r0_lock);
        end
    end
`endif

    // Grant decision; nothing is accepted while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
`ifdef SRAM_ARB_LOCK_EN
            if (own_active) begin
                gnt0 = !own_idx;
                gnt1 = own_idx;
            end else
`endif
            if (r0_req && r1_req) begin
                // Contention: the requester that was not served last wins.
                gnt0 = last_grant;
                gnt1 = !last_grant;
            end else begin
                gnt0 = r0_req;
                gnt1 = r1_req;
            end
        end
    end

    assign r0_gnt = gnt0;
    assign r1_gnt = gnt1;
    assign xfer   = gnt0 || gnt1;
    assign sel    = gnt1;

    // ---- stage 1: registered SRAM command ----
    always_ff @(posedge clock) begin
        if (reset) begin
            sram_enable     <= 1'b0;
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_write_data <= '0;
            tag_p1          <= 1'b0;
            last_grant      <= 1'b1;
        end else begin
            sram_enable <= xfer;
            sram_write  <= xfer && (sel ? r1_write : r0_write);
            // Address and data hold when idle so the SRAM bus stays quiet.
            if (xfer) begin
                sram_address    <= sel ? r1_addr : r0_addr;
                sram_write_data <= sel ? r1_wdata : r0_wdata;
                tag_p1          <= sel;
                last_grant      <= sel;
            end
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    assign sel_lock = sel ? r1_lock : r0_lock;

    // Ownership is re-evaluated on every edge: it survives only while the
    // owner keeps being accepted with lock set.
    always_ff @(posedge clock) begin
        if (reset) begin
            own_vld <= 1'b0;
            own_idx <= 1'b0;
        end else begin
            own_vld <= xfer && sel_lock;
            if (xfer) begin
                own_idx <= sel;
            end
        end
    end
`endif

    // ---- stage 2: read return to the originating requester ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
            r0_rdata  <= '0;
            r1_rdata  <= '0;
        end else begin
            r0_rvalid <= sram_enable && !sram_write && !tag_p1;
            r1_rvalid <= sram_enable && !sram_write && tag_p1;
            if (sram_enable && !sram_write && !tag_p1) begin
                r0_rdata <= sram_read_data;
            end
            if (sram_enable && !sram_write && tag_p1) begin
                r1_rdata <= sram_read_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          r0_req, r0_write, r1_req, r1_write;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] sram_address;
    logic [DW-1:0] sram_write_data, sram_read_data;
    logic          sram_enable, sram_write;
    logic          lk0, lk1;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    sram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
`ifdef SRAM_ARB_LOCK_EN
        .r0_lock(lk0), .r1_lock(lk1),
`endif
        .sram_address(sram_address), .sram_write_data(sram_write_data),
        .sram_read_data(sram_read_data), .sram_enable(sram_enable),
        .sram_write(sram_write)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hC0DE_0000 + DW'(a) * 32'h101;
    endfunction

    // Generic SRAM: commits writes on the clock edge, read is combinational.
    logic [DW-1:0] sram_mem [0:255];
    logic          mem_ready = 1'b0;
    always @(posedge clock) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (sram_enable && sram_write) begin
            sram_mem[sram_address] <= sram_write_data;
        end
    end
    assign sram_read_data = sram_mem[sram_address];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: arbitration by the round-robin/lock rules, an ordered
    // memory image updated at accept time, and the command/response timing
    // (command visible the cycle after accept, response the cycle after that).
    initial begin
        logic [DW-1:0] model_mem [0:255];
        logic          last, own_v, own, eg0, eg1, s;
        logic          c_en, c_wr, c_tag;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wd, c_rd, erd0, erd1;
        logic          ev0, ev1;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
        last = 1'b1; own_v = 1'b0; own = 1'b0;
        c_en = 0; c_wr = 0; c_tag = 0; c_addr = '0; c_wd = '0; c_rd = '0;
        erd0 = '0; erd1 = '0; ev0 = 0; ev1 = 0;
        @(posedge clock);
        forever begin
            @(negedge clock);
            eg0 = 1'b0;
            eg1 = 1'b0;
            if (!reset) begin
                if (own_v && (own ? (r1_req && lk1) : (r0_req && lk0))) begin
                    eg0 = !own;
                    eg1 = own;
                end else if (r0_req && r1_req) begin
                    eg0 = (last == 1'b1);
                    eg1 = (last == 1'b0);
                end else begin
                    eg0 = r0_req;
                    eg1 = r1_req;
                end
            end
            chk("m_r0_gnt", DW'(r0_gnt), DW'(eg0));
            chk("m_r1_gnt", DW'(r1_gnt), DW'(eg1));
            chk("m_sram_enable", DW'(sram_enable), DW'(c_en));
            chk("m_sram_write", DW'(sram_write), DW'(c_wr));
            chk("m_sram_address", DW'(sram_address), DW'(c_addr));
            chk("m_sram_write_data", sram_write_data, c_wd);
            chk("m_r0_rvalid", DW'(r0_rvalid), DW'(ev0));
            chk("m_r1_rvalid", DW'(r1_rvalid), DW'(ev1));
            chk("m_r0_rdata", r0_rdata, erd0);
            chk("m_r1_rdata", r1_rdata, erd1);
            if (reset) begin
                c_en = 0; c_wr = 0; c_tag = 0; c_addr = '0; c_wd = '0;
                ev0 = 0; ev1 = 0; erd0 = '0; erd1 = '0;
                last = 1'b1; own_v = 1'b0;
            end else begin
                ev0 = c_en && !c_wr && !c_tag;
                ev1 = c_en && !c_wr && c_tag;
                if (ev0) erd0 = c_rd;
                if (ev1) erd1 = c_rd;
                if (eg0 || eg1) begin
                    s = eg1;
                    c_en = 1'b1;
                    c_wr = s ? r1_write : r0_write;
                    c_addr = s ? r1_addr : r0_addr;
                    c_wd = s ? r1_wdata : r0_wdata;
                    c_tag = s;
                    if (c_wr) model_mem[c_addr] = c_wd;
                    c_rd = model_mem[c_addr];
                    last = s;
                    own_v = s ? lk1 : lk0;
                    own = s;
                end else begin
                    c_en = 1'b0;
                    c_wr = 1'b0;
                    own_v = 1'b0;
                end
            end
        end
    end

    // Present one request, wait (bounded) for its grant, then release it
    // just after the accepting edge.
    task automatic access(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string nm);
        logic seen;
        int   k;
        seen = 1'b0;
        k = 0;
        if (i == 0) begin
            r0_req = 1'b1; r0_write = w; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = 1'b1; r1_write = w; r1_addr = a; r1_wdata = d;
        end
        while (!seen && k < 20) begin
            @(negedge clock);
            seen = (i == 0) ? r0_gnt : r1_gnt;
            if (!seen) begin
                @(posedge clock);
                #1;
            end
            k++;
        end
        chk(nm, DW'(seen), DW'(1'b1));
        @(posedge clock);
        #1;
        if (i == 0) r0_req = 1'b0;
        else        r1_req = 1'b0;
    endtask

    task automatic idle(input int n);
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic g0, g1;
        reset = 1'b1;
        r0_req = 0; r0_write = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_write = 0; r1_addr = '0; r1_wdata = '0;
        lk0 = 0; lk1 = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle: nothing on the SRAM bus, no grants, no responses.
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("idle_enable", DW'(sram_enable), 0);
            chk("idle_gnt", DW'({r1_gnt, r0_gnt}), 0);
            chk("idle_rvalid", DW'({r1_rvalid, r0_rvalid}), 0);
        end
        @(posedge clock);
        #1;

        // r0 write then read back the same address.
        access(0, 1'b1, 8'h10, 32'hDEADBEEF, "t1_wr_gnt");
        access(0, 1'b0, 8'h10, 32'h0, "t1_rd_gnt");
        @(negedge clock);
        chk("t1_rvalid_early", DW'(r0_rvalid), 0);
        @(negedge clock);
        chk("t1_rvalid", DW'(r0_rvalid), 1);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_rvalid", DW'(r1_rvalid), 0);
        idle(2);

        // r1 write followed immediately by r0 read of the same address.
        access(1, 1'b1, 8'h20, 32'h12345678, "t3_wr_gnt");
        access(0, 1'b0, 8'h20, 32'h0, "t3_rd_gnt");
        @(negedge clock);
        @(negedge clock);
        chk("t3_rvalid", DW'(r0_rvalid), 1);
        chk("t3_rdata", r0_rdata, 32'h12345678);
        idle(2);

        // Both requesters read continuously from reset: grants alternate.
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        r0_req = 1; r0_write = 0; r0_addr = 8'h30;
        r1_req = 1; r1_write = 0; r1_addr = 8'h40;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            g0 = r0_gnt;
            g1 = r1_gnt;
            chk("t2_gnt_seq", DW'({g1, g0}), (n % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clock);
            #1;
            if (g0) r0_addr = r0_addr + 8'd1;
            if (g1) r1_addr = r1_addr + 8'd1;
        end
        idle(3);

        // Read accepted, then reset: response is dropped, r0 wins afterwards.
        access(0, 1'b0, 8'h10, 32'h0, "t4_rd_gnt");
        reset = 1'b1;
        r1_req = 1; r1_write = 0; r1_addr = 8'h41;
        @(negedge clock);
        chk("t4_gnt_in_reset", DW'({r1_gnt, r0_gnt}), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        r0_req = 1; r0_write = 0; r0_addr = 8'h11;
        @(negedge clock);
        chk("t4_rvalid_dropped", DW'(r0_rvalid), 0);
        chk("t4_enable", DW'(sram_enable), 0);
        chk("t4_first_gnt", DW'({r1_gnt, r0_gnt}), 1);
        @(posedge clock);
        #1;
        r0_req = 0;
        @(negedge clock);
        chk("t4_r1_gnt", DW'(r1_gnt), 1);
        @(posedge clock);
        #1;
        idle(3);

`ifdef SRAM_ARB_LOCK_EN
        // r0 locks the port for four reads while r1 keeps requesting.
        r0_req = 1; r0_write = 0; r0_addr = 8'h50; lk0 = 1;
        r1_req = 1; r1_write = 0; r1_addr = 8'h60;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            chk("t6_lock_gnt", DW'({r1_gnt, r0_gnt}), 1);
            @(posedge clock);
            #1;
            r0_addr = r0_addr + 8'd1;
            if (n == 3) lk0 = 0;
        end
        @(negedge clock);
        chk("t6_unlock_gnt", DW'({r1_gnt, r0_gnt}), 2);
        @(posedge clock);
        #1;
        idle(3);
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
